// File: rtl/lfsr_pkg.sv
// Shared types, defaults and the single-step LFSR function for the grant scheduler.
package lfsr_pkg;

  localparam int LFSR_W = 4;

  typedef logic [LFSR_W-1:0] lfsr_t;

  localparam lfsr_t SEED_DEF = 4'b0001;
  localparam lfsr_t TAPS_DEF = 4'b1100;  // x^4 + x^3 + 1

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic lfsr_t lfsr_next(input lfsr_t state, input lfsr_t taps);
    return {state[LFSR_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR register: synchronous reset to SEED, load of an already-sanitised value, single step.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter lfsr_t SEED = SEED_DEF,
  parameter lfsr_t TAPS = TAPS_DEF
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  step_i,
  input  logic  load_i,
  input  lfsr_t load_value_i,
  output lfsr_t state_o
);

  lfsr_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = load_value_i;
    end else if (step_i) begin
      state_d = lfsr_next(state_q, TAPS);
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lfsr_grant_scheduler.sv
// Round-robin arbiter handing the shared LFSR word to one requester per grant;
// the LFSR advances once per grant and can be reseeded while idle.
module lfsr_grant_scheduler
  import lfsr_pkg::*;
#(
  parameter int    NUM_REQ = 4,
  parameter int    WIDTH   = LFSR_W,  // must equal LFSR_W
  parameter lfsr_t SEED    = SEED_DEF,
  parameter lfsr_t TAPS    = TAPS_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               seed_load_i,
  input  logic [WIDTH-1:0]   seed_in_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [WIDTH-1:0]   value_o,
  output logic               value_valid_o,
  output logic               busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   winner_q, winner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  lfsr_t              value_q, value_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  lfsr_t lfsr_s;
  lfsr_t load_value_s;
  logic  step_s;
  logic  load_s;

  // First requester at or above ptr, wrapping around; ptr itself if none is set.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        pick  = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  lfsr_core #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr_core (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .step_i       (step_s),
    .load_i       (load_s),
    .load_value_i (load_value_s),
    .state_o      (lfsr_s)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    winner_d     = winner_q;
    grant_d      = '0;
    value_d      = '0;
    valid_d      = 1'b0;
    busy_d       = 1'b0;
    step_s       = 1'b0;
    load_s       = 1'b0;
    // An all-zero seed would lock the LFSR, so it is replaced by SEED.
    load_value_s = (seed_in_i == '0) ? SEED : lfsr_t'(seed_in_i);
    case (state_q)
      IDLE: begin
        if (seed_load_i) begin
          load_s = 1'b1;
        end else if (|req_i) begin
          winner_d = rr_pick(req_i, rr_ptr_q);
          state_d  = GRANT;
          grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_d;
          value_d  = lfsr_s;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        step_s   = 1'b1;
        rr_ptr_d = PTR_W'((int'(winner_q) + 1) % NUM_REQ);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      winner_q <= '0;
      grant_q  <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      grant_q  <= grant_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign grant_o       = grant_q;
  assign value_o       = WIDTH'(value_q);
  assign value_valid_o = valid_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_lfsr_grant_scheduler.sv
// Randomised and directed check of lfsr_grant_scheduler against a sequence-table reference model.
module tb_lfsr_grant_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       seed_load;
  logic [3:0] seed_in;
  logic [3:0] grant;
  logic [3:0] value;
  logic       value_valid;
  logic       busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // The maximal-length sequence from the seed, as listed for x^4+x^3+1.
  logic [3:0] seq_tbl [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                               4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                               4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  // Reference model state: position in the sequence, round-robin pointer, grant phase.
  int         m_pos;
  int         m_ptr;
  int         m_winner;
  bit         m_in_grant;
  logic [3:0] m_grant;
  logic [3:0] m_value;
  logic       m_valid;

  lfsr_grant_scheduler dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .seed_load_i   (seed_load),
    .seed_in_i     (seed_in),
    .grant_o       (grant),
    .value_o       (value),
    .value_valid_o (value_valid),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int seq_index(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 15; i++) if (seq_tbl[i] == v) r = i;
    return r;
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] rq, input logic sl,
                            input logic [3:0] si);
    m_grant = 4'b0000;
    m_value = 4'b0000;
    m_valid = 1'b0;
    if (r) begin
      m_pos = 0; m_ptr = 0; m_in_grant = 1'b0;
    end else if (m_in_grant) begin
      m_pos = (m_pos + 1) % 15;
      m_ptr = (m_winner + 1) % 4;
      m_in_grant = 1'b0;
    end else if (sl) begin
      m_pos = (si == 4'b0000) ? 0 : seq_index(si);
    end else if (rq != 4'b0000) begin
      for (int k = 3; k >= 0; k--) if (rq[(m_ptr + k) % 4]) m_winner = (m_ptr + k) % 4;
      m_in_grant = 1'b1;
      m_grant = 4'b0001 << m_winner;
      m_value = seq_tbl[m_pos];
      m_valid = 1'b1;
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input logic r, input logic [3:0] rq, input logic sl,
                       input logic [3:0] si);
    rst = r; req = rq; seed_load = sl; seed_in = si;
    model_edge(r, rq, sl, si);
    @(posedge clk);
    @(negedge clk);
    chk("grant", 32'(grant), 32'(m_grant));
    chk("value", 32'(value), 32'(m_value));
    chk("valid", 32'(value_valid), 32'(m_valid));
    chk("busy",  32'(busy), 32'(m_in_grant));
  endtask

  logic [3:0] exp_vals [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011};

  initial begin
    rst = 1'b1; req = 4'b0000; seed_load = 1'b0; seed_in = 4'b0000;
    m_pos = 0; m_ptr = 0; m_winner = 0; m_in_grant = 1'b0;
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
    cycle(1'b1, 4'b1111, 1'b1, 4'b0101);
    chk("reset_grant", 32'(grant), 32'h0);

    // Single request after reset
    cycle(1'b0, 4'b0001, 1'b0, 4'b0000);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_value", 32'(value), 32'h1);
    cycle(1'b0, 4'b0000, 1'b0, 4'b0000);
    chk("t1_idle", 32'(grant), 32'h0);

    // All requesting: rotation and sequence values
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 4'b1111, 1'b0, 4'b0000);
      if (k % 2 == 0) begin
        chk("t2_grant", 32'(grant), 32'(4'b0001 << ((k / 2) % 4)));
        chk("t2_value", 32'(value), 32'(exp_vals[k / 2]));
      end
    end

    // Thirty single-requester grants wrap the period
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
    for (int k = 0; k < 60; k++) cycle(1'b0, 4'b0100, 1'b0, 4'b0000);

    // Seed load beats a same-cycle request; zero seed falls back to the reset seed
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
    cycle(1'b0, 4'b0010, 1'b1, 4'b1010);
    chk("t4_nogrant", 32'(grant), 32'h0);
    cycle(1'b0, 4'b0010, 1'b0, 4'b0000);
    chk("t4_value", 32'(value), 32'hA);
    cycle(1'b0, 4'b0000, 1'b1, 4'b0000);
    cycle(1'b0, 4'b0001, 1'b1, 4'b0000);
    cycle(1'b0, 4'b0001, 1'b0, 4'b0000);
    chk("t4_zero_seed", 32'(value), 32'h1);
    cycle(1'b0, 4'b0000, 1'b1, 4'b0110);

    // Reset in the grant cycle
    cycle(1'b0, 4'b0100, 1'b0, 4'b0000);
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
    chk("t5_busy", 32'(busy), 32'h0);
    cycle(1'b0, 4'b1111, 1'b0, 4'b0000);
    chk("t5_grant", 32'(grant), 32'h1);
    chk("t5_value", 32'(value), 32'h1);
    cycle(1'b0, 4'b0000, 1'b0, 4'b0000);

    // Pointer moves past requester 1
    cycle(1'b1, 4'b0000, 1'b0, 4'b0000);
    cycle(1'b0, 4'b0010, 1'b0, 4'b0000);
    cycle(1'b0, 4'b0000, 1'b0, 4'b0000);
    cycle(1'b0, 4'b1010, 1'b0, 4'b0000);
    chk("t6_first", 32'(grant), 32'h8);
    cycle(1'b0, 4'b0000, 1'b0, 4'b0000);
    cycle(1'b0, 4'b1010, 1'b0, 4'b0000);
    chk("t6_second", 32'(grant), 32'h2);

    // Random traffic, reseeds and occasional resets
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
